seq_mul_shift_add: RTL and testbench
====================================

// Module: seq_mul_shift_add
// PURPOSE
//   Parametrised sequential shift-and-add multiplier with an integrated FSM controller.
//   Successor to the repeated-addition multiplier:
//   - latency scales with the multiplier's MSB position, not its value
//   - start/busy/done handshake
//   - synchronous reset
//   - optional signed mode
//   Sits as a shared arithmetic unit behind a bus or controller that issues one multiply at a time.
// PARAMETERS
//   WIDTH  32  operand width in bits; product is 2*WIDTH bits; legal range >= 2
// PORTS
//   clk      in   1          rising-edge clock
//   rst      in   1          synchronous active-high reset
//   start    in   1          request; sampled only in IDLE
//   a_in     in   WIDTH      multiplicand; captured on the accepting edge
//   b_in     in   WIDTH      multiplier; captured on the accepting edge
//   busy     out  1          high while in CALC
//   done     out  1          one-cycle pulse; product valid
//   product  out  2*WIDTH    result register; held until the next accepted start
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, product=0.
//     Internal mcand, mplier and acc are cleared.
//     Reset mid-operation aborts: no done pulse; partial result is discarded.
//   FSM states:
//     IDLE -start-> CALC
//     CALC -(mplier==0)-> DONE
//     DONE -> IDLE, unconditionally
//   IDLE, start=1 at edge k: mcand = zero-extended a_in (2*WIDTH bits), mplier = b_in,
//     acc = 0, state = CALC.
//   CALC, each edge:
//     - if mplier==0: product <= acc; state <= DONE
//     - else: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1
//   Latency: DONE is entered at edge k+1+n, where n = index(MSB set in b_in)+1.
//     n = 0 when b_in = 0; maximum latency is k+1+WIDTH.
//   done=1 exactly for the cycle in DONE; busy=0 in IDLE and DONE.
//   start is ignored in CALC and DONE. No queuing.
//     Operand changes while busy have no effect.
//   A start in the cycle after done (IDLE) is accepted normally.
//   Arithmetic:
//     - all sums are 2*WIDTH bits; no overflow is possible
//     - product is updated only on DONE entry and is otherwise stable
// CONFIGURATION
//   SEQ_MUL_SIGNED_EN defined: a_in/b_in are two's complement.
//     - At accept: the magnitudes |a|, |b| are loaded; sign = a_in[W-1]^b_in[W-1] is stored.
//     - |-2^(W-1)| = 2^(W-1) fits unsigned in WIDTH bits.
//     - On DONE entry: product <= sign ? -acc : acc.
//       Negation is folded into the same edge, so latency is unchanged.
//     - n is computed from |b_in|.
//   Not defined: operands are unsigned; no sign logic is present.
// TESTING   (WIDTH=8 unless noted; k = accepting edge)
//   1. rst, then a=13, b=11, start pulse -> busy from k, product=143 (16'h008F),
//      done high after edge k+5 only.
//   2. a=255, b=255 -> product=65025 (16'hFE01), done after edge k+9 (max latency).
//   3. a=77, b=0 -> product=0, done after edge k+1; a=0, b=200 -> product=0, done after k+9.
//   4. start held high with a/b changed mid-CALC -> result is the original operands'
//      product; single done; next start accepted only from IDLE.
//   5. rst=1 at edge k+3 of a 200*200 op -> busy=0, product=0, no done;
//      then 6*7 -> 42 with normal latency.
//   6. SEQ_MUL_SIGNED_EN:
//      - -3*5 -> 16'hFFF1
//      - -128*-128 -> 16'h4000
//      - 127*-1 -> 16'hFF81
//      Without the macro: 253*5 -> 16'h04F1.

Source files
------------

// File: rtl/seq_mul_shift_add.sv
// seq_mul_shift_add: sequential shift-and-add multiplier with a three-state
// controller (IDLE -> CALC -> DONE -> IDLE) and a start/busy/done handshake.
// One bit of the multiplier is retired per CALC cycle. The op finishes when
// the remaining multiplier bits are all zero, so latency tracks the multiplier's
// MSB position instead of its value.
//
// Optional feature: define SEQ_MUL_SIGNED_EN to treat a_in/b_in as two's
// complement. Magnitudes go through the unsigned datapath. The sign is applied
// on the same edge that writes the product, so latency does not change.
module seq_mul_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_result;
  logic                 w_mplier_zero;

`ifdef SEQ_MUL_SIGNED_EN
  logic                 r_sign;
  logic                 w_sign;

  // Operand magnitudes. -(-2^(W-1)) wraps to 2^(W-1), which is still correct
  // as an unsigned W-bit value.
  always_comb begin
    w_a_mag  = a_in[WIDTH-1] ? -a_in : a_in;
    w_b_mag  = b_in[WIDTH-1] ? -b_in : b_in;
    w_sign   = a_in[WIDTH-1] ^ b_in[WIDTH-1];
    w_result = r_sign ? -r_acc : r_acc;
  end
`else
  // Unsigned build: operands pass straight through and there is no sign logic.
  always_comb begin
    w_a_mag  = a_in;
    w_b_mag  = b_in;
    w_result = r_acc;
  end
`endif

  assign w_mplier_zero = (r_mplier == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_CALC;
      S_CALC: begin
        busy = 1'b1;
        if (w_mplier_zero) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: load on accept, then shift-and-add until the multiplier drains.
  // The product register is written only on the CALC->DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      r_sign    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc    <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            r_sign   <= w_sign;
`endif
          end
        end
        S_CALC: begin
          if (w_mplier_zero) begin
            r_product <= w_result;
          end else begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Bench for seq_mul_shift_add at WIDTH=8. The driver pushes the expected
// product and completion cycle when it issues an op. The monitor pops them
// on each done pulse.
module tb_seq_mul_shift_add;
  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a_in, b_in;
  logic           busy, done;
  logic [2*W-1:0] product;

  exp_t           sb[$];
  int             cyc = 0;
  int             n_tests = 0;
  int             n_fail = 0;
  int             done_cnt = 0;
  logic [2*W-1:0] last_prod = '0;

  seq_mul_shift_add #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected product and number of CALC shift cycles.
  function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SEQ_MUL_SIGNED_EN
    int sa, sb_;
    sa  = int'($signed(a));
    sb_ = int'($signed(b));
    return (2*W)'(sa * sb_);
`else
    int ua, ub;
    ua = int'(a);
    ub = int'(b);
    return (2*W)'(ua * ub);
`endif
  endfunction

  function automatic int model_n(input logic [W-1:0] b);
    logic [W-1:0] m;
`ifdef SEQ_MUL_SIGNED_EN
    m = b[W-1] ? -b : b;
`else
    m = b;
`endif
    for (int i = W-1; i >= 0; i--) if (m[i]) return i + 1;
    return 0;
  endfunction

  // Monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", product, e.prod);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 100 && (busy || done); i++) @(negedge clk);
    if (i >= 100) chk("idle_timeout", 0, 1);
  endtask

  // Issue one op. If hold is set, start stays high and the operands are
  // scrambled while the op is in CALC. Returns on the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    exp_t e;
    int   i;
    wait_idle();
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    e.prod = model_prod(a, b);
    e.cyc  = cyc + 2 + model_n(b);
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("busy_at_accept", busy, 1);
    chk("product_hold", product, last_prod);
    for (i = 0; i < 40 && !done; i++) begin
      if (hold) begin
        a_in = W'($urandom);
        b_in = W'($urandom);
      end
      @(negedge clk);
    end
    if (i >= 40) chk("done_timeout", 0, 1);
    chk("busy_in_done", busy, 0);
    last_prod = e.prod;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic, max latency, and zero-operand cases.
    run_op(8'd13, 8'd11, 1'b0);
    chk("p_13x11", product, 16'h008F);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd77, 8'd0, 1'b0);
    run_op(8'd0, 8'd200, 1'b0);

    // Start held high with operands changing mid-op. Start stays high through
    // the DONE cycle, where it must be ignored.
    run_op(8'd100, 8'd201, 1'b1);
    @(negedge clk);
    chk("start_ignored_in_done", busy, 0);
    start = 1'b0;
    // Back-to-back op issued from the IDLE cycle right after done.
    run_op(8'd9, 8'd17, 1'b0);

    // Reset asserted mid-op: the op is aborted with no done pulse.
    wait_idle();
    a_in = 8'd200; b_in = 8'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_product", product, 0);
    last_prod = '0;
    begin
      int d0;
      d0 = done_cnt;
      repeat (12) @(negedge clk);
      chk("abort_no_done", done_cnt, d0);
    end
    run_op(8'd6, 8'd7, 1'b0);
    chk("p_6x7", product, 16'd42);

`ifdef SEQ_MUL_SIGNED_EN
    run_op(8'hFD, 8'd5, 1'b0);
    chk("p_m3x5", product, 16'hFFF1);
    run_op(8'h80, 8'h80, 1'b0);
    chk("p_m128xm128", product, 16'h4000);
    run_op(8'd127, 8'hFF, 1'b0);
    chk("p_127xm1", product, 16'hFF81);
`else
    run_op(8'd253, 8'd5, 1'b0);
    chk("p_253x5", product, 16'h04F1);
`endif

    // Random unsigned/signed sweep through the model.
    for (int t = 0; t < 20; t++) run_op(W'($urandom), W'($urandom), 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
